// File: rtl/servo_pos_ramp.sv
// -----------------------------------------------------------------------------
// servo_pos_ramp
//   Command stage in front of the servo PWM generator. Takes target positions
//   over a valid/ready handshake and slews the position output toward the
//   target by a bounded step, once per PWM frame (frame_tick). pos only changes
//   on a frame boundary, so every PWM pulse is glitch-free.
//
//   Handshake: a command transfers on a rising mclk edge where
//   cmd_valid && cmd_ready. cmd_pos and cmd_step are sampled only on that
//   edge. cmd_ready depends on the registered state alone, never on cmd_*.
//
//   Optional feature: define SWEEP_TEST_EN to add a self-test triangle sweep
//   (entered from IDLE while sweep_en = 1). Without it, sweep_en is ignored.
//
// Ports:
//   mclk        system clock, 50 MHz
//   rst_n       asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command can be accepted this cycle (IDLE or RAMP)
//   cmd_pos     requested target position (clamped to POS_MAX)
//   cmd_step    per-frame slew step, 0 selects STEP_DEFAULT
//   frame_tick  one-cycle pulse at the start of each PWM frame
//   sweep_en    self-test sweep request (SWEEP_TEST_EN builds only)
//   pos         current position to the PWM stage
//   busy        state is not IDLE
//   at_target   state is IDLE and pos equals target
//   cmd_err     one-cycle pulse: accepted cmd_pos was above POS_MAX
// -----------------------------------------------------------------------------
module servo_pos_ramp #(
   parameter int POS_W        = 16,
   parameter int POS_MAX      = 50000,
   parameter int POS_INIT     = 25000,
   parameter int STEP_DEFAULT = 1000
) (
   input  logic             mclk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [POS_W-1:0] cmd_pos,
   input  logic [POS_W-1:0] cmd_step,
   input  logic             frame_tick,
   input  logic             sweep_en,
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic             at_target,
   output logic             cmd_err
);

   localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
   localparam logic [POS_W-1:0] STEP_DEF_V = POS_W'(STEP_DEFAULT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RAMP = 2'd2
`ifdef SWEEP_TEST_EN
      , SWEEP = 2'd3
`endif
   } state_t;

   state_t           state_r, state_nx;
   logic [POS_W-1:0] pos_r, pos_nx;
   logic [POS_W-1:0] target_r, target_nx;
   logic [POS_W-1:0] step_r, step_nx;
   logic             err_nx;
   logic             busy_r, at_target_r, err_r;
   logic             accept;
   logic             moving_up;
   logic [POS_W:0]   diff;
`ifdef SWEEP_TEST_EN
   logic             dir_up_r, dir_up_nx;
   logic [POS_W:0]   sweep_sum;
`endif

   assign cmd_ready = (state_r == IDLE) || (state_r == RAMP);
   assign accept    = cmd_valid && cmd_ready;

   // Distance to target in one extra bit so neither direction can wrap.
   // Stepping only happens when diff > step_r, which keeps pos strictly
   // between its old value and target, hence inside [0, POS_MAX].
   assign moving_up = target_r > pos_r;
   assign diff      = moving_up ? ({1'b0, target_r} - {1'b0, pos_r})
                                : ({1'b0, pos_r} - {1'b0, target_r});

   always_comb begin
      state_nx  = state_r;
      pos_nx    = pos_r;
      target_nx = target_r;
      step_nx   = step_r;
      err_nx    = 1'b0;
`ifdef SWEEP_TEST_EN
      dir_up_nx = dir_up_r;
      sweep_sum = {1'b0, pos_r} + {1'b0, STEP_DEF_V};
`endif
      if (accept) begin
         // A new command beats a simultaneous frame_tick; the tick is dropped.
         target_nx = (cmd_pos > POS_MAX_V) ? POS_MAX_V : cmd_pos;
         err_nx    = cmd_pos > POS_MAX_V;
         step_nx   = (cmd_step == '0) ? STEP_DEF_V : cmd_step;
         state_nx  = LOAD;
      end else begin
         case (state_r)
            IDLE: begin
`ifdef SWEEP_TEST_EN
               if (sweep_en) begin
                  state_nx  = SWEEP;
                  dir_up_nx = 1'b1;
               end
`endif
            end
            LOAD: state_nx = (target_r != pos_r) ? RAMP : IDLE;
            RAMP: begin
               if (frame_tick) begin
                  if (diff <= {1'b0, step_r}) begin
                     pos_nx   = target_r;
                     state_nx = IDLE;
                  end else if (moving_up) begin
                     pos_nx = pos_r + step_r;
                  end else begin
                     pos_nx = pos_r - step_r;
                  end
               end
            end
`ifdef SWEEP_TEST_EN
            SWEEP: begin
               if (!sweep_en) begin
                  state_nx  = IDLE;
                  target_nx = pos_r;
               end else if (frame_tick) begin
                  // Triangle: clamp at each end and reverse direction there.
                  if (dir_up_r) begin
                     if (sweep_sum >= {1'b0, POS_MAX_V}) begin
                        pos_nx    = POS_MAX_V;
                        dir_up_nx = 1'b0;
                     end else begin
                        pos_nx = sweep_sum[POS_W-1:0];
                     end
                  end else begin
                     if (pos_r <= STEP_DEF_V) begin
                        pos_nx    = '0;
                        dir_up_nx = 1'b1;
                     end else begin
                        pos_nx = pos_r - STEP_DEF_V;
                     end
                  end
               end
            end
`endif
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         pos_r       <= POS_INIT_V;
         target_r    <= POS_INIT_V;
         step_r      <= STEP_DEF_V;
         busy_r      <= 1'b0;
         at_target_r <= 1'b1;
         err_r       <= 1'b0;
`ifdef SWEEP_TEST_EN
         dir_up_r    <= 1'b1;
`endif
      end else begin
         state_r     <= state_nx;
         pos_r       <= pos_nx;
         target_r    <= target_nx;
         step_r      <= step_nx;
         // Status flags track the values being loaded on this same edge.
         busy_r      <= state_nx != IDLE;
         at_target_r <= (state_nx == IDLE) && (pos_nx == target_nx);
         err_r       <= err_nx;
`ifdef SWEEP_TEST_EN
         dir_up_r    <= dir_up_nx;
`endif
      end
   end

   assign pos       = pos_r;
   assign busy      = busy_r;
   assign at_target = at_target_r;
   assign cmd_err   = err_r;

`ifndef SWEEP_TEST_EN
   logic unused_sweep;
   assign unused_sweep = sweep_en;
`endif

endmodule
